led_status_sequencer: RTL and testbench

Controller that shares the board's single status LED between several status requesters and the alive heartbeat. It contains a tick prescaler and a round-robin arbiter. It plays each granted requester's blink code as N pulses followed by a dark gap. With no requests pending it falls back to a free-running heartbeat toggle. It sits at the top level next to the board I/O and drives one LED pin.

---
 rtl/led_status_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_led_status_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_status_sequencer.sv
// led_status_sequencer
//   Shares the single board status LED between NUM_REQ status requesters and
//   the idle heartbeat. A prescaler produces a slow blink tick. On each tick
//   the sequencer either advances the blink code of the granted requester or,
//   when nobody is asking, toggles the heartbeat. Requesters are picked
//   round-robin, and each code plays as N high pulses followed by a dark gap.
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   enable  in   global run; low freezes prescaler, FSM, counters and outputs
//   req     in   [NUM_REQ]   level requests, bit i = requester i
//   code    in   [3*NUM_REQ] pulse count per requester, [3i+2:3i] = requester i
//   led_out out  LED drive (registered)
//   grant   out  [NUM_REQ]   one-hot requester being shown, 0 when idle
//   busy    out  high while a blink code or its gap is playing
module led_status_sequencer #(
  parameter int TICK_COUNTS = 12_500_000,
  parameter int HB_TICKS    = 2,
  parameter int GAP_TICKS   = 4,
  parameter int NUM_REQ     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   code,
  output logic                   led_out,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy
);

  localparam int PS_W  = $clog2(TICK_COUNTS);
  localparam int HB_W  = (HB_TICKS  > 1) ? $clog2(HB_TICKS)  : 1;
  localparam int GP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int PTR_W = $clog2(NUM_REQ);

  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_COUNTS - 1);
  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HB_TICKS - 1);
  localparam logic [GP_W-1:0]  GP_LAST = GP_W'(GAP_TICKS - 1);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [1:0]       state;
  logic [2:0]       remaining;
  logic [HB_W-1:0]  hb_cnt;
  logic [GP_W-1:0]  gap_cnt;
  logic [PTR_W-1:0] ptr;

  // ---------------------------------------------------------------------------
  // Prescaler: one tick every TICK_COUNTS enabled cycles. Holding the count
  // while enable is low keeps the tick phase across a freeze.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc <= '0;
    else if (enable)
      presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
  end

  assign tick = enable && (presc == PS_LAST);

  // ---------------------------------------------------------------------------
  // Round-robin search: walk ptr+1, ptr+2, ... wrapping, first set req wins.
  // The walk also picks out the winner's code so the FSM can latch it in the
  // same tick.
  // ---------------------------------------------------------------------------
  logic               win_any;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [2:0]         win_code;
  logic [2:0]         win_len;

  always_comb begin
    int idx;
    idx      = 0;
    win_any  = 1'b0;
    win_idx  = '0;
    win_oh   = '0;
    win_code = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_any && req[PTR_W'(idx)]) begin
        win_any  = 1'b1;
        win_idx  = PTR_W'(idx);
        win_oh   = NUM_REQ'(1) << idx;
        win_code = 3'(code >> (3 * idx));
      end
    end
  end

  // A zero code still shows one pulse so the requester is visible.
  assign win_len = (win_code == 3'd0) ? 3'd1 : win_code;

  // ---------------------------------------------------------------------------
  // Sequencer. Everything below advances only on tick; outputs are registered
  // and change on the tick edge itself.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      led_out   <= 1'b0;
      grant     <= '0;
      busy      <= 1'b0;
      remaining <= 3'd0;
      hb_cnt    <= '0;
      gap_cnt   <= '0;
      ptr       <= PTR_RST;
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (win_any) begin
            grant     <= win_oh;
            ptr       <= win_idx;
            remaining <= win_len;
            led_out   <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ON;
          end else if (hb_cnt == HB_LAST) begin
            hb_cnt  <= '0;
            led_out <= ~led_out;
          end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
          end
        end

        S_ON: begin
          led_out   <= 1'b0;
          remaining <= remaining - 3'd1;
          // Last pulse just ended: the dark gap begins now.
          if (remaining == 3'd1) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            state <= S_OFF;
          end
        end

        S_OFF: begin
          led_out <= 1'b1;
          state   <= S_ON;
        end

        S_GAP: begin
          if (gap_cnt == GP_LAST) begin
            // Pending requests chain straight into the next code; otherwise
            // fall back to a heartbeat that starts dark with a fresh count.
            if (win_any) begin
              grant     <= win_oh;
              ptr       <= win_idx;
              remaining <= win_len;
              led_out   <= 1'b1;
              state     <= S_ON;
            end else begin
              grant   <= '0;
              busy    <= 1'b0;
              hb_cnt  <= '0;
              led_out <= 1'b0;
              state   <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GP_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          led_out <= 1'b0;
          grant   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_sequencer.sv
// Bench for led_status_sequencer. A schedule-based model (per-tick queue of
// LED levels) runs alongside the DUT and is compared every cycle, with a few
// directed scenarios adding literal checks.
module tb_led_status_sequencer;

  localparam int TC  = 4;
  localparam int HB  = 2;
  localparam int GAP = 3;
  localparam int N   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [N-1:0]     req;
  logic [3*N-1:0]   code;
  logic             led_out;
  logic [N-1:0]     grant;
  logic             busy;

  always #5 clk = ~clk;

  led_status_sequencer #(
    .TICK_COUNTS(TC), .HB_TICKS(HB), .GAP_TICKS(GAP), .NUM_REQ(N)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .code(code),
    .led_out(led_out), .grant(grant), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: when a code is granted, its whole per-tick LED pattern
  // (pulses then gap) is pushed into a queue; each tick pops one entry. An
  // empty queue is a decision point: arbitrate, drop to idle, or heartbeat.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         led;
    logic [N-1:0] gnt;
  } ent_t;

  ent_t         sched[$];
  logic         m_led;
  logic [N-1:0] m_grant;
  logic         m_busy;
  int           m_ptr, m_hb, m_edges;

  task automatic m_reset();
    m_led = 1'b0; m_grant = '0; m_busy = 1'b0;
    m_ptr = N - 1; m_hb = 0; m_edges = 0;
    sched.delete();
  endtask

  task automatic m_apply(input ent_t e);
    m_led = e.led; m_grant = e.gnt; m_busy = 1'b1;
  endtask

  task automatic m_tick();
    ent_t e;
    int   w, n, j;
    if (sched.size() > 0) begin
      m_apply(sched.pop_front());
    end else if (req != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && req[j]) w = j;
      end
      m_ptr = w;
      n = int'(code[3*w +: 3]);
      if (n == 0) n = 1;
      e.gnt = '0;
      e.gnt[w] = 1'b1;
      for (int p = 0; p < 2*n - 1; p++) begin
        e.led = (p % 2 == 0);
        sched.push_back(e);
      end
      for (int g = 0; g < GAP; g++) begin
        e.led = 1'b0;
        sched.push_back(e);
      end
      m_apply(sched.pop_front());
    end else if (m_busy) begin
      m_led = 1'b0; m_grant = '0; m_busy = 1'b0; m_hb = 0;
    end else begin
      m_hb++;
      if (m_hb == HB) begin
        m_hb  = 0;
        m_led = ~m_led;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else if (enable) begin
        m_edges++;
        if (m_edges % TC == 0) m_tick();
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_cmp++;
        if (led_out !== m_led || grant !== m_grant || busy !== m_busy) begin
          n_bad++;
          $display("FAIL model_cmp: dut led=%b grant=%b busy=%b, model led=%b grant=%b busy=%b at %0t",
                   led_out, grant, busy, m_led, m_grant, m_busy, $time);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int c;
    c = 0;
    while (busy !== lvl && c < 200) begin
      step(1);
      c++;
    end
    chk(nm, 32'(busy), 32'(lvl));
  endtask

  logic [N-1:0] seq [4];
  logic [N-1:0] prev;
  int           got, hi;

  initial begin
    rst = 1'b1; enable = 1'b0; req = '0; code = '0;
    step(3);
    chk_en = 1'b1;

    // Reset state, then idle heartbeat.
    chk("reset_led",   32'(led_out), 0);
    chk("reset_grant", 32'(grant),   0);
    chk("reset_busy",  32'(busy),    0);
    rst = 1'b0; enable = 1'b1;
    step(7);
    chk("hb_low_e7", 32'(led_out), 0);
    step(1);
    chk("hb_rise_e8", 32'(led_out), 1);
    chk("model_hb_rise_e8", 32'(m_led), 1);
    step(8);
    chk("hb_fall_e16", 32'(led_out), 0);
    chk("hb_grant", 32'(grant), 0);
    chk("hb_busy",  32'(busy),  0);

    // Single 3-pulse code from requester 2, held for repeats.
    do_reset();
    req = 4'b0100; code = 12'(3) << 6;
    wait_busy(1'b1, "single_busy");
    chk("single_grant", 32'(grant), 32'h4);
    step(4);
    chk("single_off", 32'(led_out), 0);
    step(4);
    chk("single_on2", 32'(led_out), 1);
    step(60);
    req = '0;
    step(40);

    // Round robin between 0 and 3, one pulse each.
    do_reset();
    req = 4'b1001; code = {3'd1, 3'd1, 3'd1, 3'd1};
    prev = '0; got = 0;
    for (int c = 0; c < 300 && got < 4; c++) begin
      step(1);
      if (grant !== prev && grant !== '0) begin
        seq[got] = grant;
        got++;
      end
      prev = grant;
    end
    chk("rr_count", 32'(got), 4);
    chk("rr_g0", 32'(seq[0]), 32'h1);
    chk("rr_g1", 32'(seq[1]), 32'h8);
    chk("rr_g2", 32'(seq[2]), 32'h1);
    chk("rr_g3", 32'(seq[3]), 32'h8);
    req = '0;
    step(30);

    // Code 0 plays as one pulse.
    do_reset();
    req = 4'b0010; code = '0;
    wait_busy(1'b1, "zero_busy");
    step(4);
    chk("zero_gap_dark", 32'(led_out), 0);
    step(12);
    chk("zero_repeat_on", 32'(led_out), 1);
    chk("zero_repeat_grant", 32'(grant), 32'h2);
    req = '0;
    wait_busy(1'b0, "zero_idle");

    // Requester drops after the first pulse of a 3-pulse code.
    do_reset();
    req = 4'b0010; code = 12'(3) << 3;
    wait_busy(1'b1, "drop_busy");
    hi = (led_out === 1'b1) ? 1 : 0;
    for (int c = 0; c < 200; c++) begin
      step(1);
      if (c == 4) req = '0;
      if (busy !== 1'b1) break;
      if (led_out === 1'b1) hi++;
    end
    chk("drop_high_cycles", 32'(hi), 12);
    chk("drop_idle_grant", 32'(grant), 0);
    chk("drop_idle_busy",  32'(busy),  0);

    // Enable freeze inside an ON phase.
    do_reset();
    req = 4'b0001; code = 12'(3);
    wait_busy(1'b1, "frz_busy");
    step(1);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk("frz_led",   32'(led_out), 1);
      chk("frz_grant", 32'(grant),   32'h1);
      chk("frz_busyv", 32'(busy),    1);
    end
    enable = 1'b1;
    step(2);
    chk("frz_resume_on", 32'(led_out), 1);
    step(1);
    chk("frz_resume_off", 32'(led_out), 0);
    req = '0;
    step(40);

    // Reset during OFF of a 5-pulse code.
    do_reset();
    req = 4'b0001; code = 12'(5);
    wait_busy(1'b1, "rst_busy");
    step(5);
    rst = 1'b1;
    #1;
    chk("rst_async_led",   32'(led_out), 0);
    chk("rst_async_grant", 32'(grant),   0);
    chk("rst_async_busy",  32'(busy),    0);
    step(1);
    req = 4'b0011;
    rst = 1'b0;
    wait_busy(1'b1, "rst_rebusy");
    chk("rst_first_grant", 32'(grant), 32'h1);
    req = '0;
    step(40);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0)   req  = N'($urandom);
      if ($urandom_range(15) == 0)  code = (3*N)'($urandom);
      enable = ($urandom_range(9) != 0);
      rst    = ($urandom_range(599) == 0);
      step(1);
    end
    rst = 1'b0; enable = 1'b1;
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
